// File: rtl/filter_pkg.sv
// Shared defaults and state encoding for the 3x3 filter window sequencer.
package filter_pkg;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int PAD_W = IMG_W + 2;
  localparam int AW    = 7;

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
endpackage

// File: rtl/filter_scan_counter.sv
// Raster row/column counter over the padded frame; column wraps into the next row with no bubble.
module filter_scan_counter #(
  parameter int PAD_W = 66,
  parameter int ROWS  = 64,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last_col,
  output logic          last_row
);
  assign last_col = (col == AW'(PAD_W - 1));
  assign last_row = (row == AW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + AW'(1);
      end else begin
        col <= col + AW'(1);
      end
    end
  end
endmodule

// File: rtl/filter_window_sequencer.sv
// Drives column reads over the padded frame, shifts returned columns into the window
// and presents one result per completed 3x3 window under a valid/ready handshake.
module filter_window_sequencer #(
  parameter int IMG_W = filter_pkg::IMG_W,
  parameter int IMG_H = filter_pkg::IMG_H,
  parameter int AW    = filter_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          mem_rd,
  output logic [AW-1:0] mem_row,
  output logic [AW-1:0] mem_col,
  output logic          win_shift,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_row,
  output logic [AW-1:0] out_col,
  output logic          busy,
  output logic          done
);
  import filter_pkg::*;

  localparam int PAD_W = IMG_W + 2;

  state_t        state;
  logic          advance, last_col, last_row, final_hs;
  logic          pend;
  logic [AW-1:0] pend_col, pend_row;

  // Whole pipe moves only when the result register is free or being drained.
  assign advance   = !out_valid | out_ready;
  assign mem_rd    = (state == RUN) & advance;
  assign win_shift = pend & advance;
  assign final_hs  = (state == LAST) & out_valid & out_ready & !pend;

  filter_scan_counter #(.PAD_W(PAD_W), .ROWS(IMG_H), .AW(AW)) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mem_rd),
    .row      (mem_row),
    .col      (mem_col),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pend      <= 1'b0;
      pend_col  <= '0;
      pend_row  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (en) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN:  if (mem_rd && last_col && last_row) state <= LAST;
        LAST: if (final_hs) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // The pending tag names the column the memory is presenting this cycle.
      if (mem_rd) begin
        pend     <= 1'b1;
        pend_col <= mem_col;
        pend_row <= mem_row;
      end else if (win_shift) begin
        pend <= 1'b0;
      end

      // Columns 0 and 1 of each row only prime the window; column c completes window c-2.
      if (win_shift) begin
        if (pend_col >= AW'(2)) begin
          out_valid <= 1'b1;
          out_row   <= pend_row;
          out_col   <= pend_col - AW'(2);
        end else begin
          out_valid <= 1'b0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
